// File: rtl/btn_conditioner.sv
// btn_conditioner
// Turns a raw, bouncing push-button pin into clean control signals for the
// clock-setting logic:
//   level     - debounced pressed state (1 = pressed)
//   press_p   - one-cycle pulse when a press is accepted
//   release_p - one-cycle pulse when a release is accepted
//   long      - high from the first auto-repeat until release
//   step_p    - press_p plus one pulse per auto-repeat
// Pipeline: 2-flop synchroniser -> debounce counter -> press/repeat FSM.
// A pin change sampled at edge k shows up on the outputs at edge
// k + 3 + DEBOUNCE_CYCLES.
// Optional build macro BTN_REPEAT_ACCEL_EN: after 8 auto-repeats the repeat
// interval shortens to REPEAT_CYCLES/4 (minimum 1) until the button is released.
// The interface has no valid/ready handshake; every output is a plain
// registered level or a single-cycle pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic press_p,
  output logic release_p,
  output logic long,
  output logic step_p
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_REPEAT  = 2'd2
  } state_t;

  // Pin converted to pressed polarity (1 = pressed) before synchronising.
  logic w_pin_pressed;
  assign w_pin_pressed = ACTIVE_LOW ? ~btn : btn;

  logic r_sync1;
  logic r_sync2;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_pin_pressed;
      r_sync2 <= r_sync1;
    end
  end

  logic            r_stable;
  logic [DB_W-1:0] r_db_cnt;

  // Debounce: a new level is accepted only after it has differed from the
  // accepted level for DEBOUNCE_CYCLES+1 consecutive cycles; any agreement
  // restarts the count, so shorter glitches never reach the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_sync2 == r_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_MAX) begin
      r_stable <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // Repeat interval selection: the compare value for the repeat counter.
  logic [REP_W-1:0] w_rep_last;

`ifdef BTN_REPEAT_ACCEL_EN
  localparam int FAST_CYCLES = (REPEAT_CYCLES / 4 < 1) ? 1 : REPEAT_CYCLES / 4;
  localparam logic [REP_W-1:0] FAST_LAST = REP_W'(FAST_CYCLES - 1);

  // Saturating count of auto-repeats in the current hold; bit 3 set means
  // at least 8 repeats have fired.
  logic [3:0] r_rep_num;
  assign w_rep_last = r_rep_num[3] ? FAST_LAST : REP_LAST;
`else
  assign w_rep_last = REP_LAST;
`endif

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [REP_W-1:0]    r_rep_cnt;
  logic                r_level;
  logic                r_press_p;
  logic                r_release_p;
  logic                r_long;
  logic                r_step_p;

  // Press / long-press / auto-repeat FSM with registered outputs. A release
  // is checked before the repeat timer so it wins over a repeat due in the
  // same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= '0;
      r_rep_cnt   <= '0;
      r_level     <= 1'b0;
      r_press_p   <= 1'b0;
      r_release_p <= 1'b0;
      r_long      <= 1'b0;
      r_step_p    <= 1'b0;
`ifdef BTN_REPEAT_ACCEL_EN
      r_rep_num   <= '0;
`endif
    end else begin
      r_press_p   <= 1'b0;
      r_release_p <= 1'b0;
      r_step_p    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_stable) begin
            r_state    <= S_PRESSED;
            r_press_p  <= 1'b1;
            r_step_p   <= 1'b1;
            r_level    <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        S_PRESSED: begin
          if (!r_stable) begin
            r_state     <= S_IDLE;
            r_release_p <= 1'b1;
            r_level     <= 1'b0;
            r_long      <= 1'b0;
            r_hold_cnt  <= '0;
            r_rep_cnt   <= '0;
`ifdef BTN_REPEAT_ACCEL_EN
            r_rep_num   <= '0;
`endif
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= S_REPEAT;
            r_step_p   <= 1'b1;
            r_long     <= 1'b1;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
`ifdef BTN_REPEAT_ACCEL_EN
            r_rep_num  <= r_rep_num + 4'd1;
`endif
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        S_REPEAT: begin
          if (!r_stable) begin
            r_state     <= S_IDLE;
            r_release_p <= 1'b1;
            r_level     <= 1'b0;
            r_long      <= 1'b0;
            r_hold_cnt  <= '0;
            r_rep_cnt   <= '0;
`ifdef BTN_REPEAT_ACCEL_EN
            r_rep_num   <= '0;
`endif
          end else if (r_rep_cnt == w_rep_last) begin
            r_step_p  <= 1'b1;
            r_rep_cnt <= '0;
`ifdef BTN_REPEAT_ACCEL_EN
            if (r_rep_num != 4'hF) begin
              r_rep_num <= r_rep_num + 4'd1;
            end
`endif
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign level     = r_level;
  assign press_p   = r_press_p;
  assign release_p = r_release_p;
  assign long      = r_long;
  assign step_p    = r_step_p;

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner with small timing parameters.
// The reference model works on the sampled pin stream: a new level is
// accepted once DEBOUNCE+1 consecutive samples disagree with the accepted
// level, and the corresponding press/release appears 3 edges after the last
// of those samples. Step/long expectations are closed-form offsets from the
// press time.
`timescale 1ns/1ps
module tb_btn_conditioner;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;
  localparam int F = (R / 4 < 1) ? 1 : R / 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn = 1'b1;
  logic level, press_p, release_p, long, step_p;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model state
  bit   m_acc = 1'b0;
  int   m_run = 0;
  int   ev_t[$];
  bit   ev_v[$];
  bit   m_pressed = 1'b0;
  int   m_p = 0;
  logic [4:0] m_out = '0;

  // observed pulse bookkeeping
  int n_press = 0;
  int n_release = 0;
  int n_step = 0;
  int t_press = -1;
  int t_release = -1;
  int step_t[$];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn(btn),
    .level(level),
    .press_p(press_p),
    .release_p(release_p),
    .long(long),
    .step_p(step_p)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // k = cycles since the first auto-repeat was due
  function automatic bit repeat_due(int k);
    if (k < 0) return 1'b0;
`ifdef BTN_REPEAT_ACCEL_EN
    if (k <= 7 * R) return (k % R) == 0;
    return ((k - 7 * R) % F) == 0;
`else
    return (k % R) == 0;
`endif
  endfunction

  // expected number of step pulses for a hold with pressed cycles P..last
  function automatic int steps_for(int held);
    int k;
    k = held - H;
    if (k < 0) return 1;
`ifdef BTN_REPEAT_ACCEL_EN
    if (k <= 7 * R) return 2 + k / R;
    return 9 + (k - 7 * R) / F;
`else
    return 2 + k / R;
`endif
  endfunction

  task automatic model_clear();
    m_acc = 1'b0;
    m_run = 0;
    ev_t.delete();
    ev_v.delete();
    m_pressed = 1'b0;
    m_out = '0;
  endtask

  // advance one clock edge, update the model, sample the DUT 1ns later
  task automatic tick();
    bit x;
    bit pe;
    bit re;
    bit lg;
    bit st;
    @(posedge clk);
    cyc++;
    pe = 1'b0;
    re = 1'b0;
    if (!reset_n) begin
      model_clear();
    end else begin
      x = ~btn;
      if (ev_t.size() > 0 && ev_t[0] == cyc) begin
        if (ev_v[0]) begin
          m_pressed = 1'b1;
          m_p = cyc;
          pe = 1'b1;
        end else begin
          m_pressed = 1'b0;
          re = 1'b1;
        end
        void'(ev_t.pop_front());
        void'(ev_v.pop_front());
      end
      if (x != m_acc) begin
        m_run++;
        if (m_run == D + 1) begin
          m_acc = x;
          m_run = 0;
          ev_t.push_back(cyc + 3);
          ev_v.push_back(x);
        end
      end else begin
        m_run = 0;
      end
    end
    lg = m_pressed && (cyc - m_p >= H);
    st = m_pressed && (pe || repeat_due(cyc - m_p - H));
    m_out = {m_pressed, pe, re, lg, st};
    #1;
    if (press_p) begin n_press++; t_press = cyc; end
    if (release_p) begin n_release++; t_release = cyc; end
    if (step_p) begin n_step++; step_t.push_back(cyc); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== 5'b00000) begin
        bad++;
        $display("FAIL reset_state cyc=%0d got=%b want=00000", cyc, {level, press_p, release_p, long, step_p});
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
    total++;
    if (n_press + n_release + n_step != 0) begin
      bad++;
      $display("FAIL idle_pulses got=%0d want=0", n_press + n_release + n_step);
    end
  endtask

  task automatic test_press_release();
    int k;
    int m;
    t_press = -1;
    t_release = -1;
    btn = 1'b0;
    k = cyc + 1;
    for (int i = 0; i < 35; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL press cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
    total++;
    if (t_press != k + 7) begin
      bad++;
      $display("FAIL press_latency got=%0d want=%0d", t_press, k + 7);
    end
    btn = 1'b1;
    m = cyc + 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL release cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
    total++;
    if (t_release != m + 7) begin
      bad++;
      $display("FAIL release_latency got=%0d want=%0d", t_release, m + 7);
    end
  endtask

  task automatic test_bounce();
    int p0;
    int r0;
    int s0;
    int g;
    int k;
    p0 = n_press;
    r0 = n_release;
    s0 = n_step;
    for (int rep = 0; rep < 5; rep++) begin
      for (int w = 1; w <= 3; w++) begin
        btn = 1'b0;
        for (int i = 0; i < w; i++) begin
          tick();
          total++;
          if ({level, press_p, release_p, long, step_p} !== m_out) begin
            bad++;
            $display("FAIL bounce_low cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
          end
        end
        btn = 1'b1;
        g = $urandom_range(1, 4);
        for (int i = 0; i < g; i++) begin
          tick();
          total++;
          if ({level, press_p, release_p, long, step_p} !== m_out) begin
            bad++;
            $display("FAIL bounce_high cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
          end
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL bounce_tail cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
    total++;
    if ((n_press - p0) + (n_release - r0) + (n_step - s0) != 0) begin
      bad++;
      $display("FAIL bounce_pulses got=%0d want=0", (n_press - p0) + (n_release - r0) + (n_step - s0));
    end
    btn = 1'b0;
    k = cyc + 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL bounce_settle cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
    total++;
    if (t_press != k + 7 || n_press - p0 != 1) begin
      bad++;
      $display("FAIL bounce_press got_t=%0d got_n=%0d want_t=%0d want_n=1", t_press, n_press - p0, k + 7);
    end
    btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL bounce_release cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
  endtask

  task automatic test_hold(input int hold_len);
    int p;
    int q;
    int s0;
    int idx;
    s0 = n_step;
    idx = step_t.size();
    btn = 1'b0;
    p = cyc + 1 + 7;
    while (cyc < p + hold_len) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL hold cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
    btn = 1'b1;
    q = cyc + 1 + 7;
    for (int i = 0; i < 15; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL hold_release cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
    total++;
    if (n_step - s0 != steps_for(q - 1 - p)) begin
      bad++;
      $display("FAIL hold_step_count hold=%0d got=%0d want=%0d", hold_len, n_step - s0, steps_for(q - 1 - p));
    end
    total++;
    if (step_t.size() < idx + 3) begin
      bad++;
      $display("FAIL hold_step_times got_n=%0d want_n>=3", step_t.size() - idx);
    end else if (step_t[idx] != p || step_t[idx + 1] != p + H || step_t[idx + 2] != p + H + R) begin
      bad++;
      $display("FAIL hold_step_times got=%0d,%0d,%0d want=%0d,%0d,%0d", step_t[idx], step_t[idx + 1], step_t[idx + 2], p, p + H, p + H + R);
    end
    total++;
    if (t_release != q || long !== 1'b0) begin
      bad++;
      $display("FAIL hold_end got_t=%0d got_long=%b want_t=%0d want_long=0", t_release, long, q);
    end
  endtask

  task automatic test_reset_mid_press();
    int p;
    int e;
    btn = 1'b0;
    p = cyc + 1 + 7;
    while (cyc < p + 22) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL midrst_hold cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
    reset_n = 1'b0;
    model_clear();
    #1;
    total++;
    if ({level, press_p, release_p, long, step_p} !== 5'b00000) begin
      bad++;
      $display("FAIL midrst_async got=%b want=00000", {level, press_p, release_p, long, step_p});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== 5'b00000) begin
        bad++;
        $display("FAIL midrst_held cyc=%0d got=%b want=00000", cyc, {level, press_p, release_p, long, step_p});
      end
    end
    reset_n = 1'b1;
    e = cyc + 1;
    for (int i = 0; i < 14; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL midrst_repress cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
    total++;
    if (t_press != e + 7) begin
      bad++;
      $display("FAIL midrst_press_latency got=%0d want=%0d", t_press, e + 7);
    end
    btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL midrst_release cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
  endtask

  task automatic test_random();
    int len;
    logic prev_pr;
    logic prev_rl;
    logic prev_st;
    prev_pr = 1'b0;
    prev_rl = 1'b0;
    prev_st = 1'b0;
    for (int seg = 0; seg < 60; seg++) begin
      btn = ~btn;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(25, 45) : $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        tick();
        total++;
        if ({level, press_p, release_p, long, step_p} !== m_out) begin
          bad++;
          $display("FAIL random cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
        end
        total++;
`ifdef BTN_REPEAT_ACCEL_EN
        if ((press_p && prev_pr) || (release_p && prev_rl)) begin
`else
        if ((press_p && prev_pr) || (release_p && prev_rl) || (step_p && prev_st)) begin
`endif
          bad++;
          $display("FAIL random_double_pulse cyc=%0d got=%b%b%b want=no repeat", cyc, press_p, release_p, step_p);
        end
        prev_pr = press_p;
        prev_rl = release_p;
        prev_st = step_p;
      end
    end
    btn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      total++;
      if ({level, press_p, release_p, long, step_p} !== m_out) begin
        bad++;
        $display("FAIL random_drain cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
      end
    end
  endtask

`ifdef BTN_REPEAT_ACCEL_EN
  task automatic test_accel();
    int idx;
    for (int pass = 0; pass < 2; pass++) begin
      idx = step_t.size();
      btn = 1'b0;
      for (int i = 0; i < 80; i++) begin
        tick();
        total++;
        if ({level, press_p, release_p, long, step_p} !== m_out) begin
          bad++;
          $display("FAIL accel cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
        end
      end
      total++;
      if (step_t.size() < idx + 10) begin
        bad++;
        $display("FAIL accel_spacing got_n=%0d want_n>=10", step_t.size() - idx);
      end else if (step_t[idx + 8] - step_t[idx + 7] != R || step_t[idx + 9] - step_t[idx + 8] != F) begin
        bad++;
        $display("FAIL accel_spacing got=%0d,%0d want=%0d,%0d", step_t[idx + 8] - step_t[idx + 7], step_t[idx + 9] - step_t[idx + 8], R, F);
      end
      btn = 1'b1;
      for (int i = 0; i < 15; i++) begin
        tick();
        total++;
        if ({level, press_p, release_p, long, step_p} !== m_out) begin
          bad++;
          $display("FAIL accel_release cyc=%0d got=%b want=%b", cyc, {level, press_p, release_p, long, step_p}, m_out);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_hold(60);
    test_hold($urandom_range(30, 70));
    test_reset_mid_press();
    test_random();
`ifdef BTN_REPEAT_ACCEL_EN
    test_accel();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
